// File: rtl/iir_recursive_mac.sv
// Recursive all-pole Q16.16 filter, y[n] = x[n] - sum_k c[k]*y[n-1-k], using one shared multiplier.
// Optional output/feedback clamping is enabled by defining SATURATE_EN.
module iir_recursive_mac #(
   parameter int DATA_W = 32,
   parameter int FRAC   = 16,
   parameter int ORDER  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              coef_we,
   input  logic [2:0]        coef_addr,
   input  logic [DATA_W-1:0] coef_wdata
);

   localparam int ACC_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                   state_r;
   logic        [ACC_W-1:0]  acc_r;
   logic        [2:0]        k_r;
   logic        [DATA_W-1:0] coef_r [ORDER];
   logic        [DATA_W-1:0] hist_r [ORDER];
   logic        [DATA_W-1:0] coef_sel_s;
   logic        [DATA_W-1:0] hist_sel_s;
   logic signed [ACC_W-1:0]  prod_s;

   // Drops the fractional bits of the accumulator; overflow either wraps or clamps.
   function automatic logic [DATA_W-1:0] scale_out(input logic [ACC_W-1:0] a);
`ifdef SATURATE_EN
      logic [DATA_W-FRAC:0] top;
      top = a[ACC_W-1:FRAC+DATA_W-1];
      if ((top == {(DATA_W-FRAC+1){1'b0}}) || (top == {(DATA_W-FRAC+1){1'b1}})) begin
         return a[FRAC+DATA_W-1:FRAC];
      end else if (a[ACC_W-1]) begin
         return {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         return {1'b0, {(DATA_W-1){1'b1}}};
      end
`else
      return a[FRAC+DATA_W-1:FRAC];
`endif
   endfunction

   // Selects the current tap's coefficient and history word for the shared multiplier.
   always_comb begin
      coef_sel_s = {DATA_W{1'b0}};
      hist_sel_s = {DATA_W{1'b0}};
      for (int i = 0; i < ORDER; i++) begin
         if (k_r == 3'(i)) begin
            coef_sel_s = coef_r[i];
            hist_sel_s = hist_r[i];
         end else begin
            coef_sel_s = coef_sel_s;
            hist_sel_s = hist_sel_s;
         end
      end
   end

   assign prod_s = signed'({{DATA_W{coef_sel_s[DATA_W-1]}}, coef_sel_s})
                 * signed'({{DATA_W{hist_sel_s[DATA_W-1]}}, hist_sel_s});

   // Control FSM with coefficient storage, history and registered stream outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         acc_r     <= {ACC_W{1'b0}};
         k_r       <= 3'd0;
         out_data  <= {DATA_W{1'b0}};
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         for (int i = 0; i < ORDER; i++) begin
            coef_r[i] <= {DATA_W{1'b0}};
            hist_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         case (state_r)
            IDLE: begin
               // The write and an accept share this edge, so the new tap is seen by MAC.
               for (int i = 0; i < ORDER; i++) begin
                  if (coef_we && (coef_addr == 3'(i))) begin
                     coef_r[i] <= coef_wdata;
                  end
               end
               if (in_valid) begin
                  acc_r    <= {{(DATA_W-FRAC){in_data[DATA_W-1]}}, in_data, {FRAC{1'b0}}};
                  k_r      <= 3'd0;
                  in_ready <= 1'b0;
                  state_r  <= MAC;
               end
            end
            MAC: begin
               acc_r <= acc_r - prod_s;
               if (k_r == 3'(ORDER - 1)) begin
                  state_r <= OUT;
               end else begin
                  k_r <= k_r + 3'd1;
               end
            end
            OUT: begin
               if (!out_valid) begin
                  out_data  <= scale_out(acc_r);
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  // History moves only on the handshake so a stalled output leaves it intact.
                  for (int i = ORDER - 1; i > 0; i--) begin
                     hist_r[i] <= hist_r[i-1];
                  end
                  hist_r[0] <= out_data;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iir_recursive_mac.sv
// Directed self-checking bench for iir_recursive_mac (ORDER=2, Q16.16).
module tb_iir_recursive_mac;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] in_data = 32'h0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        coef_we = 1'b0;
   logic [2:0]  coef_addr = 3'd0;
   logic [31:0] coef_wdata = 32'h0;

   int checks = 0;
   int failures = 0;

   iir_recursive_mac #(.DATA_W(32), .FRAC(16), .ORDER(2)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic write_coef(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      coef_we = 1'b1; coef_addr = a; coef_wdata = d;
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   // Waits for out_valid after an accept; lat is clocks from the accepting edge, -1 on timeout.
   task automatic wait_out(output logic [31:0] y, output int lat);
      lat = -1;
      y = 32'hx;
      for (int i = 0; i <= 20; i++) begin
         if (out_valid === 1'b1) begin
            lat = i; y = out_data;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Presents one sample, returns its result and completes the output handshake.
   task automatic run_sample(input logic [31:0] x, output logic [31:0] y, output int lat);
      int n;
      @(negedge clk);
      in_data = x; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(y, lat);
      @(negedge clk);
   endtask

   task automatic test_reset();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_state got valid=%b ready=%b data=%h exp valid=0 ready=1 data=00000000",
                  out_valid, in_ready, out_data);
      end
   endtask

   task automatic test_pass_through();
      logic [31:0] y;
      int lat;
      write_coef(3'd4, 32'h00008000);
      run_sample(32'h00030000, y, lat);
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL t1_latency got=%0d exp=3", lat); end
      checks++;
      if (y !== 32'h00030000) begin failures++; $display("FAIL t1_out0 got=%h exp=00030000", y); end
      run_sample(32'h00050000, y, lat);
      checks++;
      if (y !== 32'h00050000) begin failures++; $display("FAIL t1_out1 got=%h exp=00050000", y); end
   endtask

   task automatic test_impulse_half();
      logic [31:0] y;
      logic [31:0] exp_y [4];
      int lat;
      exp_y[0] = 32'h00010000; exp_y[1] = 32'hFFFF8000;
      exp_y[2] = 32'h00004000; exp_y[3] = 32'hFFFFE000;
      do_reset();
      // Coefficient write on the same edge as the impulse accept.
      in_data = 32'h00010000; in_valid = 1'b1;
      coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 32'h00008000;
      @(negedge clk);
      in_valid = 1'b0; coef_we = 1'b0;
      wait_out(y, lat);
      @(negedge clk);
      checks++;
      if (y !== exp_y[0]) begin failures++; $display("FAIL t2_out0 got=%h exp=%h", y, exp_y[0]); end
      for (int i = 1; i < 4; i++) begin
         run_sample(32'h0, y, lat);
         checks++;
         if (y !== exp_y[i]) begin failures++; $display("FAIL t2_out%0d got=%h exp=%h", i, y, exp_y[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] y;
      int lat;
      do_reset();
      write_coef(3'd0, 32'h00008000);
      @(negedge clk);
      in_data = 32'h00010000; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(y, lat);
      checks++;
      if (y !== 32'h00010000) begin failures++; $display("FAIL t3_first got=%h exp=00010000", y); end
      in_data = 32'h12345678; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'h00010000 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL t3_stall%0d got valid=%b data=%h ready=%b exp valid=1 data=00010000 ready=0",
                     i, out_valid, out_data, in_ready);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL t3_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
      end
      run_sample(32'h0, y, lat);
      checks++;
      if (y !== 32'hFFFF8000) begin failures++; $display("FAIL t3_next got=%h exp=ffff8000", y); end
   endtask

   task automatic test_overflow();
      logic [31:0] y;
      int lat;
      do_reset();
      write_coef(3'd0, 32'hFFFE0000);
      run_sample(32'h40000000, y, lat);
      checks++;
      if (y !== 32'h40000000) begin failures++; $display("FAIL t4_out0 got=%h exp=40000000", y); end
      run_sample(32'h40000000, y, lat);
      checks++;
`ifdef SATURATE_EN
      if (y !== 32'h7FFFFFFF) begin failures++; $display("FAIL t4_out1 got=%h exp=7fffffff", y); end
`else
      if (y !== 32'hC0000000) begin failures++; $display("FAIL t4_out1 got=%h exp=c0000000", y); end
`endif
      run_sample(32'h0, y, lat);
      checks++;
`ifdef SATURATE_EN
      if (y !== 32'h7FFFFFFF) begin failures++; $display("FAIL t4_feedback got=%h exp=7fffffff", y); end
`else
      if (y !== 32'h80000000) begin failures++; $display("FAIL t4_feedback got=%h exp=80000000", y); end
`endif
   endtask

   task automatic test_coef_write_busy();
      logic [31:0] y;
      int lat;
      do_reset();
      write_coef(3'd0, 32'h00008000);
      @(negedge clk);
      in_data = 32'h00010000; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 32'h0;
      @(negedge clk);
      coef_we = 1'b0;
      wait_out(y, lat);
      @(negedge clk);
      checks++;
      if (y !== 32'h00010000) begin failures++; $display("FAIL t5_out0 got=%h exp=00010000", y); end
      run_sample(32'h0, y, lat);
      checks++;
      if (y !== 32'hFFFF8000) begin failures++; $display("FAIL t5_out1 got=%h exp=ffff8000", y); end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] y;
      int lat;
      do_reset();
      write_coef(3'd0, 32'h00008000);
      run_sample(32'h00020000, y, lat);
      @(negedge clk);
      in_data = 32'h00010000; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
         failures++;
         $display("FAIL t6_async got valid=%b ready=%b data=%h exp valid=0 ready=1 data=00000000",
                  out_valid, in_ready, out_data);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL t6_stale got=%b exp=0", out_valid); end
      run_sample(32'h00010000, y, lat);
      checks++;
      if (y !== 32'h00010000) begin failures++; $display("FAIL t6_out0 got=%h exp=00010000", y); end
      run_sample(32'h00010000, y, lat);
      checks++;
      if (y !== 32'h00010000) begin failures++; $display("FAIL t6_coef_cleared got=%h exp=00010000", y); end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_pass_through();
      test_impulse_half();
      test_backpressure();
      test_overflow();
      test_coef_write_busy();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
